sweep_ctrl: RTL and testbench

- Sequencer for the 16-bit up/down counter (ports clk, rst, dir, zero, cntr). It drives the counter's dir and zero inputs so the counter produces a programmable number of triangle sweeps, 0 -> hi -> 0.
- Single start/busy/done handshake toward the host logic. Supports abort and a sticky error flag.
- Sits beside the counter. The counter's cntr output feeds back into this block.

---
 rtl/sweep_ctrl.sv | 116 +++++++++++
 tb/tb_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - triangle sweep sequencer driving an up/down counter
module sweep_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] hi,
    input  logic [CNT_W-1:0] cycles,
    input  logic [WIDTH-1:0] cntr,
    output logic             dir,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             peak,
    output logic             err,
    output logic [CNT_W-1:0] left
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO = '0;
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic             err_q, err_d;

    // State and program registers; reset drops any running program at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            left_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            left_q  <= left_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; in UP/DOWN abort beats the range check beats the sweep
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        left_d  = left_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (hi == W_ZERO || cycles == C_ZERO) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        hi_d    = hi;
                        left_d  = cycles;
                        err_d   = 1'b0;
                        state_d = S_UP;
                    end
                end
            end
            S_UP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cntr > hi_q) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (cntr == hi_q - W_ONE) begin
                    // hi_q is never zero here: a zero peak is refused at start
                    state_d = S_DOWN;
                end
            end
            S_DOWN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cntr > hi_q) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (cntr == W_ONE) begin
                    if (left_q > C_ONE) begin
                        left_d  = left_q - C_ONE;
                        state_d = S_UP;
                    end else begin
                        left_d  = '0;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs: the counter is held clear whenever no sweep is running
    assign zero = (state_q == S_IDLE) || (state_q == S_DONE);
    assign dir  = (state_q == S_DOWN);
    assign busy = (state_q == S_UP) || (state_q == S_DOWN);
    assign done = (state_q == S_DONE);
    assign peak = (state_q == S_DOWN) && (cntr == hi_q);
    assign err  = err_q;
    assign left = left_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - scoreboard bench for sweep_ctrl with a counter model
module tb_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] hi = '0;
    logic [7:0]  cycles = '0;
    logic [15:0] cntr;
    logic        dir, zero, busy, done, peak, err;
    logic [7:0]  left;

    logic [15:0] cnt_q = '0;
    logic        load_en = 1'b0;
    logic [15:0] load_val = '0;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int cntr;
        bit dir;
        bit peak;
        bit busy;
        bit done;
        bit err;
        bit chk_left;
        int left;
    } exp_t;

    exp_t exp_q[$];

    sweep_ctrl #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .hi(hi), .cycles(cycles), .cntr(cntr),
        .dir(dir), .zero(zero), .busy(busy), .done(done),
        .peak(peak), .err(err), .left(left)
    );

    always #5 clk = ~clk;

    // behavioural up/down counter with clear priority and a test load hook
    always @(posedge clk) begin
        if (load_en)   cnt_q <= load_val;
        else if (zero) cnt_q <= '0;
        else if (dir)  cnt_q <= cnt_q - 16'd1;
        else           cnt_q <= cnt_q + 16'd1;
    end
    assign cntr = cnt_q;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // expected trace of a sweep, cycle t counted from the first busy cycle
    task automatic push_prog(input int h, input int c, input int last_t, input bit with_done);
        exp_t e;
        for (int t = 0; t <= last_t; t++) begin
            int p;
            p = t % (2 * h);
            e.cntr = (p <= h) ? p : 2 * h - p;
            e.dir = (p >= h);
            e.peak = (p == h);
            e.busy = 1'b1;
            e.done = 1'b0;
            e.err = 1'b0;
            e.chk_left = 1'b1;
            e.left = c - t / (2 * h);
            exp_q.push_back(e);
        end
        if (with_done) begin
            e.cntr = 0; e.dir = 1'b0; e.peak = 1'b0; e.busy = 1'b0;
            e.done = 1'b1; e.err = 1'b0; e.chk_left = 1'b1; e.left = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_prog(input int h, input int c, input int abort_at);
        int total;
        exp_t e;
        total = 2 * h * c;
        @(negedge clk);
        hi = 16'(h); cycles = 8'(c); start = 1'b1;
        if (h == 0 || c == 0) begin
            e.cntr = 0; e.dir = 1'b0; e.peak = 1'b0; e.busy = 1'b0;
            e.done = 1'b1; e.err = 1'b1; e.chk_left = 1'b0; e.left = 0;
            exp_q.push_back(e);
            @(negedge clk);
            start = 1'b0;
            repeat (2) @(negedge clk);
        end else if (abort_at >= 0) begin
            push_prog(h, c, abort_at, 1'b0);
            @(negedge clk);
            start = 1'b0;
            repeat (abort_at) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_zero", zero, 1);
            chk("abort_err_kept", err, 0);
            @(negedge clk);
            chk("abort_cntr_cleared", cntr, 0);
        end else begin
            push_prog(h, c, total - 1, 1'b1);
            @(negedge clk);
            start = 1'b0;
            // a start while busy must be ignored, not queued
            hi = 16'($urandom_range(1, 9)); cycles = 8'($urandom_range(1, 9)); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (total + 2) @(negedge clk);
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // monitor: pops an expectation for every busy or done cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (busy || done) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_busy_done", {30'd0, busy, done}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cntr", cntr, e.cntr);
                        chk("busy", busy, e.busy);
                        chk("done", done, e.done);
                        chk("zero", zero, !e.busy);
                        chk("peak", peak, e.peak);
                        chk("err", err, e.err);
                        if (e.busy) chk("dir", dir, e.dir);
                        if (e.chk_left) chk("left", left, e.left);
                    end
                end else begin
                    chk("idle_zero", zero, 1);
                    chk("idle_dir", dir, 0);
                    chk("idle_peak", peak, 0);
                end
            end
        end
    end

    initial begin
        int h, c, ab;
        #1;
        chk("rst_zero", zero, 1);
        chk("rst_dir", dir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_left", left, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_cntr_held", cntr, 0);

        run_prog(3, 2, -1);
        run_prog(1, 3, -1);
        run_prog(0, 5, -1);
        chk("zero_hi_err", err, 1);
        run_prog(10, 1, 4);

        // force an out-of-range count while sweeping up to 5
        @(negedge clk);
        hi = 16'd5; cycles = 8'd1; start = 1'b1;
        push_prog(5, 1, 2, 1'b0);
        begin
            exp_t e;
            e.cntr = 20; e.dir = 1'b0; e.peak = 1'b0; e.busy = 1'b1;
            e.done = 1'b0; e.err = 1'b0; e.chk_left = 1'b1; e.left = 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        load_en = 1'b1; load_val = 16'd20;
        @(negedge clk);
        load_en = 1'b0;
        @(negedge clk);
        chk("sanity_busy", busy, 0);
        chk("sanity_err", err, 1);
        chk("sanity_zero", zero, 1);
        chk("sanity_queue", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        run_prog(2, 1, -1);
        chk("err_cleared", err, 0);

        for (int i = 0; i < 12; i++) begin
            h = $urandom_range(1, 6);
            c = $urandom_range(1, 3);
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) h = 0; else c = 0;
            end
            ab = -1;
            if (h != 0 && c != 0 && $urandom_range(0, 3) == 0)
                ab = $urandom_range(0, 2 * h * c - 1);
            run_prog(h, c, ab);
        end

        // asynchronous reset while sweeping down
        @(negedge clk);
        hi = 16'd4; cycles = 8'd2; start = 1'b1;
        push_prog(4, 2, 15, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_dir", dir, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_zero", zero, 1);
        chk("async_busy", busy, 0);
        chk("async_err", err, 0);
        chk("async_left", left, 0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_cntr", cntr, 0);
        chk("post_reset_busy", busy, 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
